udp_gbn_traffic_gen: RTL and testbench

Synthesizable traffic generator that emits Go-Back-N data packets as a UDP header stream plus a payload stream. It drives host_stack's s_udp_hdr_* and s_udp_payload_axis_* inputs directly and replaces the scripted AXI4-Stream VIP master. Packet count, payload length and start sequence number are runtime-configurable. A rewind input re-issues packets from an earlier sequence number, exercising GBN retransmission in hardware.

---
 rtl/udp_gbn_traffic_gen.sv | 190 +++++++++++++++++++
 tb/tb_udp_gbn_traffic_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_gbn_traffic_gen.sv
// rtl/udp_gbn_traffic_gen.sv - Go-Back-N UDP header + payload traffic generator
// Emits one header then a GBN beat plus N payload beats per packet; rewind re-issues older sequences.
module udp_gbn_traffic_gen #(
  parameter int DATA_WIDTH    = 64,
  parameter int SEQ_WIDTH     = 32,
  parameter int MAX_PLD_BEATS = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [31:0]               cfg_src_ip,
  input  logic [31:0]               cfg_dst_ip,
  input  logic [15:0]               cfg_src_port,
  input  logic [15:0]               cfg_dst_port,
  input  logic [7:0]                cfg_pld_beats,
  input  logic [CNT_WIDTH-1:0]      cfg_num_pkts,
  input  logic [SEQ_WIDTH-1:0]      cfg_start_seq,
  input  logic                      start,
  input  logic                      rewind_valid,
  input  logic [SEQ_WIDTH-1:0]      rewind_seq,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      sent_pkts,
  output logic [111:0]              m_hdr_tdata,
  output logic                      m_hdr_tvalid,
  input  logic                      m_hdr_tready,
  output logic [DATA_WIDTH-1:0]     m_pld_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_pld_tkeep,
  output logic                      m_pld_tlast,
  output logic                      m_pld_tuser,
  output logic                      m_pld_tvalid,
  input  logic                      m_pld_tready
);

  localparam int                   NBYTES  = DATA_WIDTH / 8;
  localparam logic [7:0]           MAX_B   = 8'(MAX_PLD_BEATS);
  localparam logic [15:0]          BYTES16 = 16'(NBYTES);
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_GBN, S_PLD, S_FIN} state_t;

  state_t                 state;
  logic [31:0]            src_ip_r, dst_ip_r;
  logic [15:0]            src_port_r, dst_port_r, hdr_len;
  logic [7:0]             beats_r, beat_k;
  logic [SEQ_WIDTH-1:0]   start_seq_r, cur_seq, end_seq, rew_seq;
  logic                   rew_pend;
  logic [CNT_WIDTH-1:0]   sent_r;
  logic                   busy_r, done_r, hdr_tvalid_r, pld_tvalid_r, pld_tlast_r;
  logic [DATA_WIDTH-1:0]  pld_tdata_r;

  logic                   hdr_hs, pld_hs, rew_hit;
  logic [SEQ_WIDTH-1:0]   rew_off, win_off, next_seq;
  logic [7:0]             beat_k_nxt, cfg_beats_cl;

  function automatic logic [DATA_WIDTH-1:0] gbn_word(input logic [SEQ_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[7:0] = 8'd3;
    w[8 +: SEQ_WIDTH] = s;
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pld_word(input logic [3:0] s, input logic [3:0] k);
    return {NBYTES{{s, k}}};
  endfunction

  // Window is measured from the run's start so sequence wrap does not break the backward-only test.
  always_comb begin
    hdr_hs       = hdr_tvalid_r && m_hdr_tready;
    pld_hs       = pld_tvalid_r && m_pld_tready;
    rew_off      = rewind_seq - start_seq_r;
    win_off      = cur_seq + SEQ_ONE - start_seq_r;
    rew_hit      = busy_r && rewind_valid && (rew_off < win_off);
    next_seq     = rew_hit ? rewind_seq : (rew_pend ? rew_seq : cur_seq + SEQ_ONE);
    beat_k_nxt   = beat_k + 8'd1;
    cfg_beats_cl = (cfg_pld_beats > MAX_B) ? MAX_B : cfg_pld_beats;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      src_ip_r     <= '0;
      dst_ip_r     <= '0;
      src_port_r   <= '0;
      dst_port_r   <= '0;
      hdr_len      <= '0;
      beats_r      <= '0;
      beat_k       <= '0;
      start_seq_r  <= '0;
      cur_seq      <= '0;
      end_seq      <= '0;
      rew_seq      <= '0;
      rew_pend     <= 1'b0;
      sent_r       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      hdr_tvalid_r <= 1'b0;
      pld_tvalid_r <= 1'b0;
      pld_tlast_r  <= 1'b0;
      pld_tdata_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (rew_hit) begin
        rew_pend <= 1'b1;
        rew_seq  <= rewind_seq;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ip_r    <= cfg_src_ip;
            dst_ip_r    <= cfg_dst_ip;
            src_port_r  <= cfg_src_port;
            dst_port_r  <= cfg_dst_port;
            beats_r     <= cfg_beats_cl;
            hdr_len     <= BYTES16 * (16'd1 + 16'(cfg_beats_cl));
            start_seq_r <= cfg_start_seq;
            cur_seq     <= cfg_start_seq;
            end_seq     <= cfg_start_seq + SEQ_WIDTH'(cfg_num_pkts);
            rew_pend    <= 1'b0;
            sent_r      <= '0;
            if (cfg_num_pkts == '0) begin
              state  <= S_FIN;
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end else begin
              state        <= S_HDR;
              busy_r       <= 1'b1;
              hdr_tvalid_r <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (hdr_hs) begin
            hdr_tvalid_r <= 1'b0;
            pld_tvalid_r <= 1'b1;
            pld_tdata_r  <= gbn_word(cur_seq);
            pld_tlast_r  <= (beats_r == 8'd0);
            beat_k       <= 8'd0;
            state        <= S_GBN;
          end
        end
        S_GBN, S_PLD: begin
          if (pld_hs) begin
            if (pld_tlast_r) begin
              // Packet boundary: a rewind arriving this very cycle is already folded into next_seq.
              sent_r       <= sent_r + CNT_ONE;
              rew_pend     <= 1'b0;
              cur_seq      <= next_seq;
              pld_tvalid_r <= 1'b0;
              pld_tlast_r  <= 1'b0;
              if (next_seq == end_seq) begin
                state  <= S_FIN;
                done_r <= 1'b1;
                busy_r <= 1'b0;
              end else begin
                state        <= S_HDR;
                hdr_tvalid_r <= 1'b1;
              end
            end else begin
              beat_k      <= beat_k_nxt;
              pld_tdata_r <= pld_word(cur_seq[3:0], beat_k_nxt[3:0]);
              pld_tlast_r <= (beat_k_nxt == beats_r);
              state       <= S_PLD;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign sent_pkts    = sent_r;
  assign m_hdr_tdata  = {hdr_len, dst_port_r, src_port_r, dst_ip_r, src_ip_r};
  assign m_hdr_tvalid = hdr_tvalid_r;
  assign m_pld_tdata  = pld_tdata_r;
  assign m_pld_tkeep  = '1;
  assign m_pld_tlast  = pld_tlast_r;
  assign m_pld_tuser  = 1'b0;
  assign m_pld_tvalid = pld_tvalid_r;

endmodule

// File: tb/tb_udp_gbn_traffic_gen.sv
// tb/tb_udp_gbn_traffic_gen.sv - scoreboard bench for udp_gbn_traffic_gen
// Stimulus pushes expected headers/beats; a negedge monitor pops and compares on every handshake.
module tb_udp_gbn_traffic_gen;

  localparam int DW = 64;
  localparam int SW = 32;
  localparam int CW = 16;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [31:0]     cfg_src_ip = 32'h0A000001;
  logic [31:0]     cfg_dst_ip = 32'h0A000002;
  logic [15:0]     cfg_src_port = 16'h1234;
  logic [15:0]     cfg_dst_port = 16'h5678;
  logic [7:0]      cfg_pld_beats = 8'd0;
  logic [CW-1:0]   cfg_num_pkts = '0;
  logic [SW-1:0]   cfg_start_seq = '0;
  logic            start = 1'b0;
  logic            rewind_valid = 1'b0;
  logic [SW-1:0]   rewind_seq = '0;
  logic            busy, done;
  logic [CW-1:0]   sent_pkts;
  logic [111:0]    m_hdr_tdata;
  logic            m_hdr_tvalid;
  logic            m_hdr_tready = 1'b1;
  logic [DW-1:0]   m_pld_tdata;
  logic [DW/8-1:0] m_pld_tkeep;
  logic            m_pld_tlast, m_pld_tuser, m_pld_tvalid;
  logic            m_pld_tready = 1'b1;

  udp_gbn_traffic_gen #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW), .MAX_PLD_BEATS(16), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .cfg_pld_beats(cfg_pld_beats), .cfg_num_pkts(cfg_num_pkts), .cfg_start_seq(cfg_start_seq),
    .start(start), .rewind_valid(rewind_valid), .rewind_seq(rewind_seq),
    .busy(busy), .done(done), .sent_pkts(sent_pkts),
    .m_hdr_tdata(m_hdr_tdata), .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
    .m_pld_tdata(m_pld_tdata), .m_pld_tkeep(m_pld_tkeep), .m_pld_tlast(m_pld_tlast),
    .m_pld_tuser(m_pld_tuser), .m_pld_tvalid(m_pld_tvalid), .m_pld_tready(m_pld_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [111:0] exp_hdr[$];
  beat_t        exp_pld[$];
  int           chk = 0;
  int           err = 0;
  int           hdr_hs_cnt = 0;
  int           pld_hs_cnt = 0;
  int           done_cnt = 0;
  bit           rand_rdy = 1'b0;
  bit           in_pkt = 1'b0;
  bit           hv_pend = 1'b0;
  bit           pv_pend = 1'b0;
  logic [111:0] h_hold;
  logic [DW:0]  p_hold;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [SW-1:0] seq, input int cfg_beats);
    int          b;
    logic [15:0] len;
    logic [7:0]  kk, by;
    beat_t       bt;
    b   = (cfg_beats > 16) ? 16 : cfg_beats;
    len = 16'(8 * (1 + b));
    exp_hdr.push_back({len, 16'h5678, 16'h1234, 32'h0A000002, 32'h0A000001});
    bt.d = '0;
    bt.d[7:0] = 8'h03;
    bt.d[8 +: SW] = seq;
    bt.l = (b == 0);
    exp_pld.push_back(bt);
    for (int k = 1; k <= b; k++) begin
      kk   = 8'(k);
      by   = {seq[3:0], kk[3:0]};
      bt.d = {8{by}};
      bt.l = (k == b);
      exp_pld.push_back(bt);
    end
  endtask

  task automatic start_run(input logic [SW-1:0] s, input logic [CW-1:0] n, input logic [7:0] b);
    cfg_start_seq = s;
    cfg_num_pkts  = n;
    cfg_pld_beats = b;
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
  endtask

  task automatic wait_cnt_hdr(input int target);
    int n = 0;
    while (hdr_hs_cnt < target && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 2000) check("hdr_wait_timeout", 1, 0);
  endtask

  task automatic wait_done(input string name, input int d0, input logic [CW-1:0] exp_sent);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 3000) check({name, "_done_timeout"}, 1, 0);
    repeat (3) @(negedge aclk);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_sent_pkts"}, sent_pkts, exp_sent);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_hdr_left"}, exp_hdr.size(), 0);
    check({name, "_pld_left"}, exp_pld.size(), 0);
  endtask

  // Ready driver: held high unless random backpressure is enabled.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_rdy) begin
        m_hdr_tready = 1'($urandom_range(0, 1));
        m_pld_tready = 1'($urandom_range(0, 1));
      end else begin
        m_hdr_tready = 1'b1;
        m_pld_tready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [111:0] eh;
    beat_t        ep;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        hv_pend = 1'b0;
        pv_pend = 1'b0;
        in_pkt  = 1'b0;
      end else begin
        if (hv_pend) begin
          check("hdr_valid_hold", m_hdr_tvalid, 1);
          check("hdr_data_hold", m_hdr_tdata, h_hold);
        end
        if (pv_pend) begin
          check("pld_valid_hold", m_pld_tvalid, 1);
          check("pld_data_hold", {m_pld_tlast, m_pld_tdata}, p_hold);
        end
        if (m_hdr_tvalid && m_hdr_tready) begin
          check("hdr_inside_pkt", in_pkt, 0);
          if (exp_hdr.size() == 0) begin
            chk++; err++;
            $display("FAIL hdr_unexpected: got %0h expected none", m_hdr_tdata);
          end else begin
            eh = exp_hdr.pop_front();
            check("hdr_tdata", m_hdr_tdata, eh);
          end
          in_pkt = 1'b1;
          hdr_hs_cnt++;
        end
        if (m_pld_tvalid && m_pld_tready) begin
          check("pld_after_hdr", in_pkt, 1);
          check("pld_tkeep_tuser", {m_pld_tkeep, m_pld_tuser}, {8'hFF, 1'b0});
          if (exp_pld.size() == 0) begin
            chk++; err++;
            $display("FAIL pld_unexpected: got %0h expected none", m_pld_tdata);
          end else begin
            ep = exp_pld.pop_front();
            check("pld_tdata_tlast", {m_pld_tlast, m_pld_tdata}, {ep.l, ep.d});
          end
          pld_hs_cnt++;
          if (m_pld_tlast) in_pkt = 1'b0;
        end
        hv_pend = m_hdr_tvalid && !m_hdr_tready;
        h_hold  = m_hdr_tdata;
        pv_pend = m_pld_tvalid && !m_pld_tready;
        p_hold  = {m_pld_tlast, m_pld_tdata};
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0, p0;
    logic [SW-1:0] seqs2 [10];
    // Reset state
    @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_pkts, 0);
    check("rst_hvalid", m_hdr_tvalid, 0);
    check("rst_pvalid", m_pld_tvalid, 0);
    #2 aresetn = 1'b1;

    // 1: three packets, two payload beats each
    for (int i = 1; i <= 3; i++) push_pkt(SW'(i), 2);
    d0 = done_cnt;
    start_run(32'd1, 16'd3, 8'd2);
    wait_done("t1", d0, 16'd3);

    // 2: rewind to 2 during the seq-5 packet
    seqs2 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    foreach (seqs2[i]) push_pkt(seqs2[i], 2);
    d0 = done_cnt;
    h0 = hdr_hs_cnt;
    start_run(32'd1, 16'd6, 8'd2);
    wait_cnt_hdr(h0 + 5);
    #1 rewind_valid = 1'b1; rewind_seq = 32'd2;
    @(posedge aclk); #1 rewind_valid = 1'b0;
    wait_done("t2", d0, 16'd10);

    // 3: idle rewind and forward rewind are both dropped
    @(posedge aclk); #1 rewind_valid = 1'b1; rewind_seq = 32'd0;
    @(posedge aclk); #1 rewind_valid = 1'b0;
    for (int i = 1; i <= 4; i++) push_pkt(SW'(i), 1);
    d0 = done_cnt;
    h0 = hdr_hs_cnt;
    start_run(32'd1, 16'd4, 8'd1);
    wait_cnt_hdr(h0 + 3);
    #1 rewind_valid = 1'b1; rewind_seq = 32'd9;
    @(posedge aclk); #1 rewind_valid = 1'b0;
    wait_done("t3", d0, 16'd4);

    // 4: random backpressure on both streams
    rand_rdy = 1'b1;
    for (int i = 0; i < 5; i++) push_pkt(32'h20 + SW'(i), 3);
    d0 = done_cnt;
    start_run(32'h20, 16'd5, 8'd3);
    wait_done("t4", d0, 16'd5);
    rand_rdy = 1'b0;

    // 5: zero packets, zero-beat packets, and beat clamp
    d0 = done_cnt;
    start_run(32'd5, 16'd0, 8'd2);
    @(negedge aclk);
    check("t5_done_next_cycle", done, 1);
    check("t5_no_hvalid", m_hdr_tvalid, 0);
    wait_done("t5a", d0, 16'd0);
    push_pkt(32'd7, 0);
    push_pkt(32'd8, 0);
    d0 = done_cnt;
    start_run(32'd7, 16'd2, 8'd0);
    wait_done("t5b", d0, 16'd2);
    push_pkt(32'd3, 20);
    d0 = done_cnt;
    start_run(32'd3, 16'd1, 8'd20);
    wait_done("t5c", d0, 16'd1);

    // 6: reset mid-payload, then a run across the sequence wrap
    for (int i = 0; i < 3; i++) push_pkt(32'h40 + SW'(i), 4);
    p0 = pld_hs_cnt;
    start_run(32'h40, 16'd3, 8'd4);
    begin
      int n = 0;
      while (pld_hs_cnt < p0 + 2 && n < 2000) begin
        @(posedge aclk);
        n++;
      end
      if (n >= 2000) check("t6_pld_wait_timeout", 1, 0);
    end
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_pvalid", m_pld_tvalid, 0);
    check("t6_rst_hvalid", m_hdr_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_sent", sent_pkts, 0);
    exp_hdr.delete();
    exp_pld.delete();
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("t6_idle_busy", busy, 0);
      check("t6_idle_valid", {m_hdr_tvalid, m_pld_tvalid}, 0);
    end
    push_pkt(32'hFFFFFFFF, 1);
    push_pkt(32'h0, 1);
    d0 = done_cnt;
    start_run(32'hFFFFFFFF, 16'd2, 8'd1);
    wait_done("t6", d0, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
